// File: rtl/joystick_spi_responder.sv
// joystick_spi_responder: PmodJSTK-compatible SPI mode-0 slave that returns an
// X/Y/button snapshot per 40-bit frame and captures the master's LED command bits.
module joystick_spi_responder #(
  parameter int         FRAME_BITS = 40,
  parameter logic [5:0] CMD_PREFIX = 6'b100000
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] btn,
  output logic       ld1,
  output logic       ld2,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);
  localparam logic [5:0] FB = 6'(FRAME_BITS);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t      state;
  logic [2:0]  sck_q, cs_q;
  logic [1:0]  mosi_q;
  logic [1:0]  warm;
  logic        armed;
  logic [5:0]  bit_cnt;
  logic [39:0] tx_shift, rx_shift;
  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  // A frame may only start once cs has been seen high through the synchronizer after reset,
  // so a frame already in progress when reset is released is ignored.
  always_ff @(posedge clk50M or negedge reset_n)
    if (!reset_n) begin
      sck_q      <= '0;
      cs_q       <= '1;
      mosi_q     <= '0;
      warm       <= '0;
      armed      <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      miso       <= 1'b0;
      ld1        <= 1'b0;
      ld2        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], sck};
      cs_q       <= {cs_q[1:0], cs};
      mosi_q     <= {mosi_q[0], mosi};
      warm       <= {warm[0], 1'b1};
      armed      <= armed | (warm[1] & cs_q[1]);
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall && armed) begin
          state    <= ACTIVE;
          busy     <= 1'b1;
          tx_shift <= {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn, 1'b0};
          miso     <= x[7];
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        busy  <= 1'b0;
        miso  <= 1'b0;
        if (bit_cnt == FB && rx_shift[39:34] == CMD_PREFIX) begin
          ld1        <= rx_shift[32];
          ld2        <= rx_shift[33];
          frame_done <= 1'b1;
        end else
          frame_err <= 1'b1;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[38:0], mosi_q[1]};
        bit_cnt  <= (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[38:0], 1'b0};
        miso     <= tx_shift[38];
      end
    end
endmodule

// File: tb/tb_joystick_spi_responder.sv
// tb_joystick_spi_responder: SPI master driving directed and random frames; a scoreboard
// queue holds the expected frame outcome that the pulse monitor pops and compares.
module tb_joystick_spi_responder;
  localparam int HALF = 10;
  logic clk50M = 0, reset_n = 0, sck = 0, cs = 1, mosi = 0;
  logic [9:0] x = 0, y = 0;
  logic [1:0] btn = 0;
  logic miso, ld1, ld2, busy, frame_done, frame_err;
  int checks = 0, errors = 0;
  typedef struct {logic done; logic l1; logic l2;} exp_t;
  exp_t sb[$];
  logic m_ld1 = 0, m_ld2 = 0;

  always #10 clk50M = ~clk50M;

  joystick_spi_responder dut (
    .clk50M(clk50M), .reset_n(reset_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .x(x), .y(y), .btn(btn), .ld1(ld1), .ld2(ld2), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reply byte stream: x low, x high, y low, y high, buttons<<1, then zeros.
  function automatic logic tx_bit(input logic [9:0] fx, input logic [9:0] fy, input logic [1:0] fb, input int i);
    int b[5];
    if (i >= 40) return 1'b0;
    b = '{int'(fx) % 256, int'(fx) / 256, int'(fy) % 256, int'(fy) / 256, int'(fb) * 2};
    return ((b[i / 8] >> (7 - i % 8)) & 1) != 0;
  endfunction

  always @(negedge clk50M)
    if (frame_done || frame_err) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_pulse", {30'b0, frame_done, frame_err}, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'b0, frame_done, frame_err}, {30'b0, e.done, !e.done});
        chk("leds", {30'b0, ld1, ld2}, {30'b0, e.l1, e.l2});
      end
    end

  task automatic run_frame(input int n, input logic [47:0] d, input int chg_at,
                           input logic [9:0] chg_x, input int abort_at);
    logic [9:0] fx, fy;
    logic [1:0] fb;
    logic [7:0] cmd;
    logic aborted, valid;
    fx = x; fy = y; fb = btn; cmd = d[47:40]; aborted = 0;
    @(negedge clk50M) cs = 0;
    repeat (3) @(negedge clk50M);
    chk("busy_rise", {31'b0, busy}, 1);
    chk("miso_first", {31'b0, miso}, {31'b0, tx_bit(fx, fy, fb, 0)});
    repeat (HALF - 3) @(negedge clk50M);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) x = chg_x;
      if (i == abort_at) begin
        reset_n = 0;
        #1;
        chk("rst_miso", {31'b0, miso}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_leds", {30'b0, ld1, ld2}, 0);
        m_ld1 = 0; m_ld2 = 0; aborted = 1;
        @(negedge clk50M) reset_n = 1;
      end
      mosi = d[47 - i];
      repeat (HALF) @(negedge clk50M);
      chk($sformatf("miso_bit%0d", i), {31'b0, miso}, aborted ? 0 : {31'b0, tx_bit(fx, fy, fb, i)});
      sck = 1;
      repeat (HALF) @(negedge clk50M);
      sck = 0;
    end
    repeat (HALF) @(negedge clk50M);
    if (!aborted) begin
      valid = (n == 40) && ((cmd >> 2) == 8'h20);
      if (valid) begin m_ld1 = cmd[0]; m_ld2 = cmd[1]; end
      sb.push_back('{valid, m_ld1, m_ld2});
    end
    cs = 1;
    repeat (2) @(negedge clk50M);
    chk("busy_hold", {31'b0, busy}, aborted ? 0 : 1);
    @(negedge clk50M);
    chk("busy_fall", {31'b0, busy}, 0);
    chk("miso_cs_high", {31'b0, miso}, 0);
    repeat (HALF) @(negedge clk50M);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int lens[6] = '{40, 40, 40, 24, 48, 39};
    logic [7:0] cmd;
    repeat (3) @(negedge clk50M);
    chk("rst_outputs", {26'b0, miso, ld1, ld2, busy, frame_done, frame_err}, 0);
    reset_n = 1;
    repeat (10) @(negedge clk50M);
    x = 10'h2A5; y = 10'h15A; btn = 2'b10;
    run_frame(40, {8'h81, 40'h0}, -1, 0, -1);
    chk("ld_after_normal", {30'b0, ld1, ld2}, 2'b10);
    x = 10'h000;
    run_frame(40, {8'h83, 40'h0}, 8, 10'h3FF, -1);
    run_frame(40, {8'h81, 40'h0}, -1, 0, -1);
    run_frame(24, {8'h82, 40'h0}, -1, 0, -1);
    run_frame(40, {8'h03, 40'h0}, -1, 0, -1);
    run_frame(48, {8'h82, 40'h0}, -1, 0, -1);
    chk("ld_kept", {30'b0, ld1, ld2}, 2'b10);
    run_frame(40, {8'h81, 40'h0}, -1, 0, 16);
    run_frame(40, {8'h82, 40'h0}, -1, 0, -1);
    chk("ld_after_reset_frame", {30'b0, ld1, ld2}, 2'b01);
    repeat (10) begin
      sck = 1;
      repeat (5) @(negedge clk50M);
      chk("idle_miso", {31'b0, miso}, 0);
      chk("idle_busy", {31'b0, busy}, 0);
      sck = 0;
      repeat (5) @(negedge clk50M);
    end
    repeat (8) begin
      x = 10'($urandom); y = 10'($urandom); btn = 2'($urandom);
      cmd = ($urandom_range(0, 3) != 0) ? 8'(8'h80 + $urandom_range(0, 3)) : 8'($urandom);
      run_frame(lens[$urandom_range(0, 5)], {cmd, 32'($urandom), 8'($urandom)}, -1, 0, -1);
    end
    repeat (20) @(negedge clk50M);
    chk("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
